// File: rtl/sys_bridge_pkg.sv
// Shared definitions for sys_bridge: FSM state encoding, slot address map
// and word-only slot mask.
package sys_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int unsigned SLOT_MAX = 4;

  // Slot order: 0 DM, 1 TC0, 2 TC1, 3 IG (index 0 is the rightmost entry)
  localparam logic [SLOT_MAX-1:0][31:0] SLOT_BASE = {
    32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000
  };
  localparam logic [SLOT_MAX-1:0][31:0] SLOT_LIMIT = {
    32'h0000_7F23, 32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_2FFF
  };
  localparam logic [SLOT_MAX-1:0] WORD_ONLY = 4'b0110;

  function automatic logic we_is_partial(input logic [3:0] we);
    return (we != 4'b0000) && (we != 4'b1111);
  endfunction

endpackage

// File: rtl/sys_bridge_decode.sv
// Combinational slot decoder: one-hot hit (lowest slot wins on overlap),
// miss flag and word-only partial-write violation.
module sys_bridge_decode
  import sys_bridge_pkg::*;
#(
  parameter int NUM_SLV = 4
) (
  input  logic [31:0]        addr,
  input  logic [3:0]         we,
  output logic [NUM_SLV-1:0] hit,
  output logic               miss,
  output logic               illegal
);

  logic        found;
  logic        word_hit;
  logic [31:0] off;

  always_comb begin
    hit      = '0;
    found    = 1'b0;
    word_hit = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      // Offset form keeps the inclusive base..limit test free of a >= 0 compare
      off = addr - SLOT_BASE[i];
      if (!found && (off <= (SLOT_LIMIT[i] - SLOT_BASE[i]))) begin
        hit[i] = 1'b1;
        found  = 1'b1;
        if (WORD_ONLY[i]) word_hit = 1'b1;
      end
    end
    miss    = !found;
    illegal = word_hit && we_is_partial(we);
  end

endmodule

// File: rtl/sys_bridge.sv
// Registered CPU-to-peripheral bridge with slot decode, bounded wait and
// one-cycle ack. Define BRIDGE_ERRLOG_EN to enable cpu_err and err_addr.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic [3:0]                cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ack,
  output logic                      cpu_err,
  output logic [31:0]               err_addr,
  output logic [NUM_SLV-1:0]        slv_sel,
  output logic [3:0]                slv_we,
  output logic [31:0]               slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ready
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t              state, state_n;
  logic [31:0]         addr_q;
  logic [3:0]          we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          cnt;
  logic                err_q;

  logic [31:0]         dec_addr;
  logic [3:0]          dec_we;
  logic [NUM_SLV-1:0]  hit;
  logic                miss;
  logic                illegal;
  logic                ready_hit;
  logic [DATA_W-1:0]   sel_rdata;

  // Decoder sees the value being latched in IDLE and the held value afterwards
  assign dec_addr = (state == ST_IDLE) ? cpu_addr : addr_q;
  assign dec_we   = (state == ST_IDLE) ? cpu_we   : we_q;

  sys_bridge_decode #(.NUM_SLV(NUM_SLV)) u_decode (
    .addr    (dec_addr),
    .we      (dec_we),
    .hit     (hit),
    .miss    (miss),
    .illegal (illegal)
  );

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (hit[i]) sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
    end
    ready_hit = |(hit & slv_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (cpu_req) state_n = (miss || illegal) ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ready_hit || (cnt == TMO)) state_n = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            rdata_q <= '0;
            cnt     <= '0;
            err_q   <= miss || illegal;
          end
        end
        ST_ACCESS: begin
          if (ready_hit) begin
            rdata_q <= (we_q == 4'b0000) ? sel_rdata : '0;
            err_q   <= 1'b0;
          end else if (cnt == TMO) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack   = (state == ST_RESP);
  assign cpu_rdata = (cpu_ack && !err_q) ? rdata_q : '0;
  assign slv_sel   = (state == ST_ACCESS) ? hit  : '0;
  assign slv_we    = (state == ST_ACCESS) ? we_q : '0;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;

`ifdef BRIDGE_ERRLOG_EN
  logic [31:0] err_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             err_addr_q <= '0;
    else if ((state == ST_RESP) && err_q)  err_addr_q <= addr_q;
  end

  assign cpu_err  = cpu_ack && err_q;
  assign err_addr = err_addr_q;
`else
  assign cpu_err  = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_sys_bridge.sv
// Directed, table-driven bench for sys_bridge (default map, TIMEOUT=15).
module tb_sys_bridge;

  localparam int NUM_SLV = 4;
  localparam int DATA_W  = 32;
`ifdef BRIDGE_ERRLOG_EN
  localparam bit ERRLOG = 1'b1;
`else
  localparam bit ERRLOG = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      cpu_req;
  logic [3:0]                cpu_we;
  logic [31:0]               cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_ack;
  logic                      cpu_err;
  logic [31:0]               err_addr;
  logic [NUM_SLV-1:0]        slv_sel;
  logic [3:0]                slv_we;
  logic [31:0]               slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [NUM_SLV-1:0]        slv_ready;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_err_addr = '0;

  always #5 clk = ~clk;

  sys_bridge #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .err_addr  (err_addr),
    .slv_sel   (slv_sel),
    .slv_we    (slv_we),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          delay;     // ACCESS cycle index at which ready rises; 255 = never
    logic [3:0]  exp_sel;
    int          exp_lat;
    logic        exp_err;   // raw error condition, before the macro gating
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int sel_cycles;
    bit acked;
    sel_cycles = 0;
    acked      = 1'b0;
    cpu_req    = 1'b1;
    cpu_addr   = v.addr;
    cpu_we     = v.we;
    cpu_wdata  = v.wdata;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acked = 1'b1;
        break;
      end
      chk("sel_during_access", 32'(slv_sel), 32'(v.exp_sel));
      chk("we_during_access", 32'(slv_we), (v.exp_sel != 0) ? 32'(v.we) : 32'd0);
      if (slv_sel != 0) sel_cycles++;
      if (k == 1 && v.exp_sel != 0) begin
        chk("slv_addr", slv_addr, v.addr);
        chk("slv_wdata", slv_wdata, v.wdata);
      end
      slv_ready = ((k - 1) == v.delay) ? v.exp_sel : 4'b0000;
    end
    slv_ready = '0;
    cpu_req   = 1'b0;
    if (!acked) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: no ack within 40 cycles for addr 0x%08h", v.addr);
    end else begin
      chk("latency", 32'(k), 32'(v.exp_lat));
      chk("sel_cycles", 32'(sel_cycles), (v.exp_sel != 0) ? 32'(v.exp_lat - 1) : 32'd0);
      chk("cpu_err", 32'(cpu_err), 32'(ERRLOG & v.exp_err));
      chk("cpu_rdata", cpu_rdata, v.exp_rdata);
      chk("sel_in_resp", 32'(slv_sel), 32'd0);
    end
    @(negedge clk);
    chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
    chk("sel_after", 32'(slv_sel), 32'd0);
    if (ERRLOG && v.exp_err) last_err_addr = v.addr;
    chk("err_addr", err_addr, ERRLOG ? last_err_addr : 32'd0);
  endtask

  initial begin
    //        addr           we       wdata         dly  sel      lat err rdata
    vecs[0]  = '{32'h0000_0010, 4'b0000, 32'h0,         0, 4'b0001,  2, 0, 32'h1234_5678};
    vecs[1]  = '{32'h0000_7F04, 4'b1111, 32'hDEAD_BEEF, 3, 4'b0010,  5, 0, 32'h0};
    vecs[2]  = '{32'h0000_7F14, 4'b0001, 32'h55,        0, 4'b0000,  1, 1, 32'h0};
    vecs[3]  = '{32'h0000_5000, 4'b0000, 32'h0,         0, 4'b0000,  1, 1, 32'h0};
    vecs[4]  = '{32'h0000_7F20, 4'b0000, 32'h0,       255, 4'b1000, 17, 1, 32'h0};
    vecs[5]  = '{32'h0000_7F18, 4'b0000, 32'h0,         1, 4'b0100,  3, 0, 32'hB2B2_B2B2};
    vecs[6]  = '{32'h0000_2FFF, 4'b0000, 32'h0,         0, 4'b0001,  2, 0, 32'h1234_5678};
    vecs[7]  = '{32'h0000_3000, 4'b0000, 32'h0,         0, 4'b0000,  1, 1, 32'h0};
    vecs[8]  = '{32'h0000_7F0C, 4'b1111, 32'h1,         0, 4'b0000,  1, 1, 32'h0};
    vecs[9]  = '{32'h0000_7F23, 4'b0000, 32'h0,        15, 4'b1000, 17, 0, 32'hC3C3_C3C3};
    vecs[10] = '{32'h0000_0020, 4'b0011, 32'hCAFE_0001, 0, 4'b0001,  2, 0, 32'h0};
    vecs[11] = '{32'h0000_7F00, 4'b0000, 32'h0,         2, 4'b0010,  4, 0, 32'hA1A1_A1A1};

    slv_rdata = {32'hC3C3_C3C3, 32'hB2B2_B2B2, 32'hA1A1_A1A1, 32'h1234_5678};
    slv_ready = '0;
    cpu_req   = 1'b0;
    cpu_we    = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_sel", 32'(slv_sel), 32'd0);
    chk("rst_we", 32'(slv_we), 32'd0);
    chk("rst_addr", slv_addr, 32'd0);
    chk("rst_wdata", slv_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset in the middle of a DM write: select and enables drop at once, no ack
    cpu_req   = 1'b1;
    cpu_addr  = 32'h0000_0040;
    cpu_we    = 4'b1111;
    cpu_wdata = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    chk("pre_rst_sel", 32'(slv_sel), 32'd1);
    chk("pre_rst_we", 32'(slv_we), 32'hF);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_sel", 32'(slv_sel), 32'd0);
    chk("async_rst_we", 32'(slv_we), 32'd0);
    chk("async_rst_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_ack_in_rst", 32'(cpu_ack), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("no_ack_after_rst", 32'(cpu_ack), 32'd0);
    last_err_addr = '0;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
